// File: rtl/tiny_ether_pkg.sv
// tiny_ether_pkg: shared state encoding, widths and default timing for the frame TX arbiter.
package tiny_ether_pkg;
   localparam int OCTET_W           = 8;
   localparam int WORD_W            = 9;
   localparam int IFG_CYCLES_DEF    = 48;
   localparam int MAX_FRAME_LEN_DEF = 1536;
   typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_GAP} state_e;
endpackage

// File: rtl/my_bin2gray.sv
// my_bin2gray: combinational binary to reflected-gray converter.
module my_bin2gray #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter: arbitrates two FWFT frame FIFOs onto one TX MAC stream with IFG and length abort.
// ARB_STRICT_PRIO_EN selects strict src0 priority; the default build uses round-robin.
module frame_tx_arbiter
   import tiny_ether_pkg::*;
#(
   parameter int IFG_CYCLES    = IFG_CYCLES_DEF,
   parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF
) (
   input  logic               REF_CLK,
   input  logic               arst_n,
   input  logic               src0_empty,
   input  logic [WORD_W-1:0]  src0_dout,
   output logic               src0_rden,
   input  logic               src1_empty,
   input  logic [WORD_W-1:0]  src1_dout,
   output logic               src1_rden,
   output logic [OCTET_W-1:0] tx_data,
   output logic               tx_valid,
   output logic               tx_last,
   output logic               tx_abort,
   input  logic               tx_ready,
   output logic               grant,
   output logic               busy,
   output logic [15:0]        frame_count_gray,
   output logic [15:0]        abort_count_gray
);
   localparam int OW = $clog2(MAX_FRAME_LEN + 1);
   localparam int GW = $clog2(IFG_CYCLES + 1);
   localparam logic [OW-1:0] OCT_LAST = OW'(MAX_FRAME_LEN - 1);
   localparam logic [GW-1:0] IFG_LOAD = GW'(IFG_CYCLES - 1);

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic [OCTET_W-1:0]  data_q, data_d;
   logic                valid_q, valid_d, last_q, last_d, abort_q, abort_d;
   logic [OW-1:0]       oct_q, oct_d;
   logic [GW-1:0]       ifg_q, ifg_d;
   logic [15:0]         frames_q, frames_d, aborts_q, aborts_d;
   logic [WORD_W-1:0]   sel_dout;
   logic                sel_empty, sel_eod, pick, pop, accept, at_max;

   assign sel_empty = grant_q ? src1_empty : src0_empty;
   assign sel_dout  = grant_q ? src1_dout : src0_dout;
   assign sel_eod   = sel_dout[WORD_W-1];
   assign accept    = valid_q & tx_ready;
   assign at_max    = oct_q == OCT_LAST;
`ifdef ARB_STRICT_PRIO_EN
   assign pick = src0_empty;
`else
   assign pick = (src0_empty | src1_empty) ? src0_empty : ~grant_q;
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      data_d   = data_q;
      valid_d  = valid_q;
      last_d   = last_q;
      abort_d  = abort_q;
      oct_d    = oct_q;
      ifg_d    = ifg_q;
      frames_d = frames_q;
      aborts_d = aborts_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!(src0_empty && src1_empty)) begin
               grant_d = pick;
               oct_d   = '0;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            // once the closing octet sits in the register, nothing more is popped
            pop = (~valid_q | tx_ready) & ~last_q & ~sel_empty;
            if (accept) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               abort_d = 1'b0;
            end
            if (pop) begin
               oct_d   = oct_q + 1'b1;
               data_d  = sel_dout[OCTET_W-1:0];
               valid_d = 1'b1;
               last_d  = sel_eod | at_max;
               abort_d = ~sel_eod & at_max;
            end
            if (accept && last_q) begin
               if (abort_q) begin
                  aborts_d = aborts_q + 16'd1;
                  state_d  = ST_DRAIN;
               end else begin
                  frames_d = frames_q + 16'd1;
                  ifg_d    = IFG_LOAD;
                  state_d  = ST_GAP;
               end
            end
         end
         ST_DRAIN: begin
            pop = ~sel_empty;
            if (pop && sel_eod) begin
               ifg_d   = IFG_LOAD;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (ifg_q == '0) state_d = ST_IDLE;
            else ifg_d = ifg_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge REF_CLK or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         abort_q  <= 1'b0;
         oct_q    <= '0;
         ifg_q    <= '0;
         frames_q <= '0;
         aborts_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         abort_q  <= abort_d;
         oct_q    <= oct_d;
         ifg_q    <= ifg_d;
         frames_q <= frames_d;
         aborts_q <= aborts_d;
      end
   end

   assign src0_rden = pop & ~grant_q;
   assign src1_rden = pop & grant_q;
   assign tx_data   = data_q;
   assign tx_valid  = valid_q;
   assign tx_last   = last_q;
   assign tx_abort  = abort_q;
   assign grant     = grant_q;
   assign busy      = state_q != ST_IDLE;

   my_bin2gray #(.WIDTH(16)) u_frame_gray (.bin_i(frames_q), .gray_o(frame_count_gray));
   my_bin2gray #(.WIDTH(16)) u_abort_gray (.bin_i(aborts_q), .gray_o(abort_count_gray));
endmodule
